// File: rtl/xor_cipher_cfg_loader.sv
// Byte-stream loader for the dual_xor_stream_cipher configuration chain.
// Collects one config image, shifts it out LSB-first, and captures the previous image as readback.
module xor_cipher_cfg_loader #(
    parameter  int M        = 32,
    localparam int CFG_BITS = 4*M + 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                cfg_en,
    output logic                cfg_i,
    input  logic                cfg_o_in,
    output logic [CFG_BITS-1:0] rb_cfg,
    output logic                busy,
    output logic                done
);

    localparam int NBYTES = (CFG_BITS + 7) / 8;
    localparam int IMG_W  = NBYTES * 8;
    localparam int BIT_W  = $clog2(CFG_BITS + 1);
    localparam int BYTE_W = $clog2(NBYTES + 1);

    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(CFG_BITS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t            state;
    logic [BYTE_W-1:0] byte_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [IMG_W-1:0]  img;
    logic              accept;

    assign accept = in_valid & in_ready;
    assign busy   = (state != IDLE);

    // Control path: state, counters, chain outputs and readback
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            in_ready <= 1'b0;
            cfg_en   <= 1'b0;
            cfg_i    <= 1'b0;
            done     <= 1'b0;
            rb_cfg   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cfg_en <= 1'b0;
                    cfg_i  <= 1'b0;
                    if (start) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        byte_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        byte_cnt <= '0;
                    end else if (accept) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            // Chain starts right away: bit 0 is already in img unless the image is one byte
                            state    <= SHIFT;
                            in_ready <= 1'b0;
                            bit_cnt  <= '0;
                            cfg_en   <= 1'b1;
                            cfg_i    <= (byte_cnt == '0) ? in_data[0] : img[0];
                        end
                    end
                end
                SHIFT: begin
                    rb_cfg  <= {cfg_o_in, rb_cfg[CFG_BITS-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state  <= DONE;
                        cfg_en <= 1'b0;
                        cfg_i  <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        cfg_i <= img[1];
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Data path: image assembly, then a right shift so the next chain bit is always img[1]
    always_ff @(posedge clk) begin
        if (state == LOAD && accept && !abort) begin
            img[{byte_cnt, 3'b000} +: 8] <= in_data;
        end else if (state == SHIFT) begin
            img <= img >> 1;
        end
    end

endmodule

// File: tb/tb_xor_cipher_cfg_loader.sv
// Randomized bench for xor_cipher_cfg_loader against a transaction-level model and a cipher chain model.
module tb_xor_cipher_cfg_loader;

    localparam int M  = 32;
    localparam int CB = 4*M + 3;
    localparam int NB = (CB + 7) / 8;

    typedef logic [7:0] img_t [NB];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready, cfg_en, cfg_i, cfg_o_in, busy, done;
    logic [CB-1:0] rb_cfg;

    always #5 clk = ~clk;

    xor_cipher_cfg_loader #(.M(M)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .cfg_en(cfg_en), .cfg_i(cfg_i), .cfg_o_in(cfg_o_in),
        .rb_cfg(rb_cfg), .busy(busy), .done(done)
    );

    // Cipher config chain: shifts in from the top, presents bit 0 on cfg_o
    logic [CB-1:0] cip;
    always @(posedge clk) begin
        if (rst)         cip <= '0;
        else if (cfg_en) cip <= {cfg_i, cip[CB-1:1]};
    end
    assign cfg_o_in = cip[0];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [CB-1:0] act, input logic [CB-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [CB-1:0] img_of(input img_t b);
        logic [CB-1:0] r = '0;
        for (int j = 0; j < NB; j++)
            for (int k = 0; k < 8; k++)
                if (8*j + k < CB) r[8*j + k] = b[j][k];
        return r;
    endfunction

    // Transaction-level model: 0 idle, 1 collecting, 2 streaming bit m_k, 3 done pulse
    int            m_mode = 0;
    int            m_n = 0;
    int            m_k = 0;
    img_t          m_arr;
    logic [CB-1:0] m_img = '0;
    logic [CB-1:0] m_old = '0;
    logic [CB-1:0] m_rb  = '0;
    int            run = 0;
    int            done_cnt = 0;

    always @(negedge clk) begin
        chk("busy",     busy,     m_mode != 0);
        chk("in_ready", in_ready, m_mode == 1 && m_n < NB);
        chk("cfg_en",   cfg_en,   m_mode == 2);
        chk("cfg_i",    cfg_i,    (m_mode == 2) ? m_img[m_k] : 1'b0);
        chk("done",     done,     m_mode == 3);
        if (m_mode != 2) chk("rb_cfg", rb_cfg, m_rb);

        if (cfg_en) run++;
        else begin
            if (run > 0) chk("cfg_en_run", run, CB);
            run = 0;
        end
        if (done) done_cnt++;

        if (rst) begin
            m_mode = 0; m_n = 0; m_rb = '0; run = 0;
        end else begin
            case (m_mode)
                0: if (start) begin m_mode = 1; m_n = 0; end
                1: begin
                    if (abort) begin
                        m_mode = 0; m_n = 0;
                    end else if (in_valid && m_n < NB) begin
                        m_arr[m_n] = in_data;
                        m_n++;
                        if (m_n == NB) begin
                            m_mode = 2; m_k = 0;
                            m_img = img_of(m_arr);
                            m_old = cip;
                        end
                    end
                end
                2: begin
                    m_k++;
                    if (m_k == CB) begin m_mode = 3; m_rb = m_old; end
                end
                default: m_mode = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gmax);
        int n = 0;
        int g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
        repeat (g) tick();
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin tick(); n++; end
        chk("in_ready_timeout", n < 50, 1'b1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic load(input img_t b, input int gmax);
        do_start();
        for (int j = 0; j < NB; j++) send(b[j], gmax);
    endtask

    task automatic wait_done(input bit poke);
        int n = 0;
        while (!done && n < 400) begin
            if (poke) begin start = 1'($urandom); abort = 1'($urandom); end
            tick();
            n++;
        end
        chk("done_timeout", n < 400, 1'b1);
        if (poke) begin start = 1'b1; abort = 1'b1; end
        tick();
        start = 1'b0;
        abort = 1'b0;
    endtask

    function automatic img_t rnd_img();
        img_t r;
        for (int j = 0; j < NB; j++) r[j] = 8'($urandom);
        return r;
    endfunction

    img_t seq, a, b, c, d, e, f;

    initial begin
        for (int j = 0; j < NB; j++) seq[j] = 8'(j + 1);
        a = rnd_img(); b = rnd_img(); c = rnd_img();
        d = rnd_img(); e = rnd_img(); f = rnd_img();

        repeat (3) tick();
        chk("rst_cfg_en", cfg_en, 1'b0);
        chk("rst_rb", rb_cfg, '0);
        rst = 1'b0;
        tick();

        // Sequential bytes, back-to-back
        load(seq, 0);
        wait_done(0);
        chk("t1_cip", cip, img_of(seq));
        chk("t1_lo", cip[15:0], 16'h0201);
        chk("t1_hi", cip[130:128], 3'b001);
        chk("t1_rb", rb_cfg, '0);
        chk("t1_done_cnt", done_cnt, 1);

        // Two random images: readback must return the first
        load(a, 0); wait_done(0);
        load(b, 0); wait_done(0);
        chk("t2_rb", rb_cfg, img_of(a));
        chk("t2_cip", cip, img_of(b));

        // Random in_valid gaps
        load(seq, 5); wait_done(0);
        chk("t3_cip", cip, img_of(seq));
        chk("t3_rb", rb_cfg, img_of(b));

        // Abort with a byte on the bus, then a clean load
        do_start();
        for (int j = 0; j < 5; j++) send(c[j], 0);
        in_data = 8'hA5; in_valid = 1'b1; abort = 1'b1;
        tick();
        in_valid = 1'b0; abort = 1'b0;
        chk("t4_busy", busy, 1'b0);
        tick();
        load(c, 0); wait_done(0);
        chk("t4_cip", cip, img_of(c));

        // start/abort noise during SHIFT and DONE
        load(d, 2); wait_done(1);
        tick();
        chk("t5_idle", busy, 1'b0);
        chk("t5_cip", cip, img_of(d));

        // Reset at shift cycle 60
        load(e, 0);
        repeat (60) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_cfg_en", cfg_en, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_rb", rb_cfg, '0);
        tick();
        load(f, 1); wait_done(0);
        chk("t6_cip", cip, img_of(f));
        chk("t6_rb_after", rb_cfg, '0);
        chk("done_total", done_cnt, 7);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
